pc_gen: RTL and testbench

- Next-generation program-counter unit for the npc core.
- Owns the PC register and computes the next fetch address from sequential flow, the full RV32I/RV64I branch set, jal and jalr (rs1+imm), trap entry and mret.
- Presents the PC to the IFU over a valid/ready handshake.
- Holds redirects that arrive while fetch is stalled, and flags misaligned targets.

---
 rtl/pc_gen.sv | 176 +++++++++++++++++
 tb/tb_pc_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: program-counter unit for the npc core.
// Owns the fetch PC, presents it to the IFU over a valid/ready handshake and
// redirects fetch on trap, mret, jal, jalr and taken conditional branches.
// A redirect latches its target and costs exactly one bubble (HOLD) before
// fetch resumes at the new address. Misaligned jal/jalr/branch targets are
// reported on misalign/misalign_addr and do not redirect.
//
// Optional build macro: PC_GEN_RVC_EN
//   defined   - adds input ifu_is_rvc; the sequential step is +2 when it is
//               high at acceptance, else +4; targets only need 2-byte alignment.
//   undefined - step is always +4; targets need 4-byte alignment.
//
// state | meaning
// ------+------------------------------------------------------------------
// BOOT  | first cycle out of reset, pc_valid=0, pc=RESET_VEC
// RUN   | pc_valid=1, pc advances on each accepted fetch
// HOLD  | redirect target latched, pc_valid=0, loaded into pc next edge

module pc_gen #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] RESET_VEC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_ready,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            br_en,
  input  logic [2:0]      br_funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            jal,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            mret,
  input  logic [XLEN-1:0] mepc,
  output logic            redirect,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr
`ifdef PC_GEN_RVC_EN
  ,
  input  logic            ifu_is_rvc
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] RESET_PC = XLEN'(RESET_VEC);
  localparam logic [XLEN-1:0] BIT0_CLR = ~XLEN'(1);

  state_t          state;
  logic [XLEN-1:0] pend_tgt;

  logic            br_taken;
  logic [XLEN-1:0] rel_tgt;
  logic [XLEN-1:0] jalr_tgt;
  logic            sel_hit;
  logic            sel_chk;
  logic [XLEN-1:0] sel_tgt;
  logic            tgt_misaligned;
  logic            mis_hit;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] pc_seq;

  // Conditional branch outcome; reserved funct3 encodings are never taken.
  always_comb begin
    br_taken = 1'b0;
    case (br_funct3)
      3'b000:  br_taken = (src1 == src2);
      3'b001:  br_taken = (src1 != src2);
      3'b100:  br_taken = ($signed(src1) <  $signed(src2));
      3'b101:  br_taken = ($signed(src1) >= $signed(src2));
      3'b110:  br_taken = (src1 <  src2);
      3'b111:  br_taken = (src1 >= src2);
      default: br_taken = 1'b0;
    endcase
  end

  assign rel_tgt  = ex_pc + imm;
  assign jalr_tgt = (src1 + imm) & BIT0_CLR;

  // Pick the highest-priority redirect source; only EX-stage jumps get an
  // alignment check, trap and mret targets come from trusted CSRs.
  always_comb begin
    sel_hit = 1'b0;
    sel_chk = 1'b0;
    sel_tgt = '0;
    if (trap) begin
      sel_hit = 1'b1;
      sel_tgt = trap_vec;
    end else if (mret) begin
      sel_hit = 1'b1;
      sel_tgt = mepc;
    end else if (ex_valid && jalr) begin
      sel_hit = 1'b1;
      sel_chk = 1'b1;
      sel_tgt = jalr_tgt;
    end else if (ex_valid && jal) begin
      sel_hit = 1'b1;
      sel_chk = 1'b1;
      sel_tgt = rel_tgt;
    end else if (ex_valid && br_en && br_taken) begin
      sel_hit = 1'b1;
      sel_chk = 1'b1;
      sel_tgt = rel_tgt;
    end
  end

`ifdef PC_GEN_RVC_EN
  assign tgt_misaligned = sel_tgt[0];
  assign pc_inc         = ifu_is_rvc ? XLEN'(2) : XLEN'(4);
`else
  assign tgt_misaligned = |sel_tgt[1:0];
  assign pc_inc         = XLEN'(4);
`endif

  assign pc_seq = pc + pc_inc;

  // Misaligned jumps are reported instead of redirecting; reset masks both.
  assign mis_hit  = !rst && sel_hit && sel_chk && tgt_misaligned;
  assign redirect = !rst && sel_hit && !(sel_chk && tgt_misaligned);

  // PC state machine with registered handshake and misalign outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      pc_valid      <= 1'b0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
      pend_tgt      <= '0;
    end else begin
      misalign <= mis_hit;
      if (mis_hit) begin
        misalign_addr <= sel_tgt;
      end
      if (redirect) begin
        // Cancels this cycle's fetch; a redirect during HOLD just re-latches.
        pend_tgt <= sel_tgt;
        state    <= HOLD;
        pc_valid <= 1'b0;
      end else begin
        case (state)
          BOOT: begin
            state    <= RUN;
            pc_valid <= 1'b1;
          end
          RUN: begin
            pc_valid <= 1'b1;
            if (if_ready) begin
              pc <= pc_seq;
            end
          end
          HOLD: begin
            pc       <= pend_tgt;
            state    <= RUN;
            pc_valid <= 1'b1;
          end
          default: begin
            state    <= BOOT;
            pc_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen (default build, XLEN=32).
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        if_ready;
  logic        pc_valid;
  logic [31:0] pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        br_en;
  logic [2:0]  br_funct3;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        jal;
  logic        jalr;
  logic [31:0] imm;
  logic        trap;
  logic [31:0] trap_vec;
  logic        mret;
  logic [31:0] mepc;
  logic        redirect;
  logic        misalign;
  logic [31:0] misalign_addr;
`ifdef PC_GEN_RVC_EN
  logic        ifu_is_rvc;
`endif

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_pc;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst), .if_ready(if_ready), .pc_valid(pc_valid), .pc(pc),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .br_en(br_en), .br_funct3(br_funct3),
    .src1(src1), .src2(src2), .jal(jal), .jalr(jalr), .imm(imm),
    .trap(trap), .trap_vec(trap_vec), .mret(mret), .mepc(mepc),
    .redirect(redirect), .misalign(misalign), .misalign_addr(misalign_addr)
`ifdef PC_GEN_RVC_EN
    , .ifu_is_rvc(ifu_is_rvc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        ev, br, jl, jr, tp, mr;
    logic [2:0]  f3;
    logic [31:0] epc, s1, s2, im, tv, mp;
    logic        exp_rd, exp_mis;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic ev, input logic br,
                              input logic [2:0] f3, input logic jl, input logic jr,
                              input logic tp, input logic mr, input logic [31:0] epc,
                              input logic [31:0] s1, input logic [31:0] s2,
                              input logic [31:0] im, input logic [31:0] tv,
                              input logic [31:0] mp, input logic exp_rd,
                              input logic exp_mis, input logic [31:0] exp_tgt);
    vec_t v;
    v.name = name; v.ev = ev; v.br = br; v.f3 = f3; v.jl = jl; v.jr = jr;
    v.tp = tp; v.mr = mr; v.epc = epc; v.s1 = s1; v.s2 = s2; v.im = im;
    v.tv = tv; v.mp = mp; v.exp_rd = exp_rd; v.exp_mis = exp_mis; v.exp_tgt = exp_tgt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_pc = '0; br_en = 0; br_funct3 = '0; src1 = '0; src2 = '0;
    jal = 0; jalr = 0; imm = '0; trap = 0; trap_vec = '0; mret = 0; mepc = '0;
  endtask

  task automatic apply(input vec_t v);
    ex_valid = v.ev; br_en = v.br; br_funct3 = v.f3; jal = v.jl; jalr = v.jr;
    trap = v.tp; mret = v.mr; ex_pc = v.epc; src1 = v.s1; src2 = v.s2;
    imm = v.im; trap_vec = v.tv; mepc = v.mp;
  endtask

  initial begin
    rst = 1; if_ready = 1;
`ifdef PC_GEN_RVC_EN
    ifu_is_rvc = 0;
`endif
    clear_ex();

    //            name              ev br f3      jl jr tp mr ex_pc          src1           src2           imm            trap_vec       mepc           rd mis target
    vecs.push_back(mk("blt_taken",    1, 1, 3'b100, 0, 0, 0, 0, 32'h8000_0100, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFF0, 32'h0,         32'h0,         1, 0, 32'h8000_00F0));
    vecs.push_back(mk("bltu_not",     1, 1, 3'b110, 0, 0, 0, 0, 32'h8000_0100, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFF0, 32'h0,         32'h0,         0, 0, 32'h0));
    vecs.push_back(mk("beq_taken",    1, 1, 3'b000, 0, 0, 0, 0, 32'h8000_0200, 32'h5,         32'h5,         32'h8,         32'h0,         32'h0,         1, 0, 32'h8000_0208));
    vecs.push_back(mk("bne_not",      1, 1, 3'b001, 0, 0, 0, 0, 32'h8000_0200, 32'h5,         32'h5,         32'h8,         32'h0,         32'h0,         0, 0, 32'h0));
    vecs.push_back(mk("bge_taken",    1, 1, 3'b101, 0, 0, 0, 0, 32'h8000_0300, 32'h1,         32'hFFFF_FFFF, 32'h10,        32'h0,         32'h0,         1, 0, 32'h8000_0310));
    vecs.push_back(mk("bgeu_not",     1, 1, 3'b111, 0, 0, 0, 0, 32'h8000_0300, 32'h1,         32'hFFFF_FFFF, 32'h10,        32'h0,         32'h0,         0, 0, 32'h0));
    vecs.push_back(mk("bltu_taken",   1, 1, 3'b110, 0, 0, 0, 0, 32'h8000_0340, 32'h1,         32'hFFFF_FFFF, 32'h4,         32'h0,         32'h0,         1, 0, 32'h8000_0344));
    vecs.push_back(mk("f3_010_not",   1, 1, 3'b010, 0, 0, 0, 0, 32'h8000_0200, 32'h5,         32'h5,         32'h8,         32'h0,         32'h0,         0, 0, 32'h0));
    vecs.push_back(mk("f3_011_not",   1, 1, 3'b011, 0, 0, 0, 0, 32'h8000_0200, 32'h1,         32'h2,         32'h8,         32'h0,         32'h0,         0, 0, 32'h0));
    vecs.push_back(mk("br_no_ev",     0, 1, 3'b000, 0, 0, 0, 0, 32'h8000_0200, 32'h5,         32'h5,         32'h8,         32'h0,         32'h0,         0, 0, 32'h0));
    vecs.push_back(mk("jalr_mis",     1, 0, 3'b000, 0, 1, 0, 0, 32'h0,         32'h8000_0201, 32'h0,         32'h2,         32'h0,         32'h0,         0, 1, 32'h8000_0202));
    vecs.push_back(mk("jalr_bit0",    1, 0, 3'b000, 0, 1, 0, 0, 32'h0,         32'h8000_0403, 32'h0,         32'h2,         32'h0,         32'h0,         1, 0, 32'h8000_0404));
    vecs.push_back(mk("jal_fwd",      1, 0, 3'b000, 1, 0, 0, 0, 32'h8000_0500, 32'h0,         32'h0,         32'h20,        32'h0,         32'h0,         1, 0, 32'h8000_0520));
    vecs.push_back(mk("jal_no_ev",    0, 0, 3'b000, 1, 0, 0, 0, 32'h8000_0500, 32'h0,         32'h0,         32'h20,        32'h0,         32'h0,         0, 0, 32'h0));
    vecs.push_back(mk("jal_mis",      1, 0, 3'b000, 1, 0, 0, 0, 32'h8000_0600, 32'h0,         32'h0,         32'h2,         32'h0,         32'h0,         0, 1, 32'h8000_0602));
    vecs.push_back(mk("br_mis",       1, 1, 3'b000, 0, 0, 0, 0, 32'h8000_0B00, 32'h5,         32'h5,         32'h6,         32'h0,         32'h0,         0, 1, 32'h8000_0B06));
    vecs.push_back(mk("trap_no_ev",   0, 0, 3'b000, 0, 0, 1, 0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h8000_1000, 32'h0,         1, 0, 32'h8000_1000));
    vecs.push_back(mk("trap_trusted", 0, 0, 3'b000, 0, 0, 1, 0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h8000_2002, 32'h0,         1, 0, 32'h8000_2002));
    vecs.push_back(mk("mret",         0, 0, 3'b000, 0, 0, 0, 1, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         32'h8000_0104, 1, 0, 32'h8000_0104));
    vecs.push_back(mk("jalr_ov_jal",  1, 0, 3'b000, 1, 1, 0, 0, 32'h8000_0800, 32'h8000_0700, 32'h0,         32'h10,        32'h0,         32'h0,         1, 0, 32'h8000_0710));
    vecs.push_back(mk("mret_ov_jalr", 1, 0, 3'b000, 0, 1, 0, 1, 32'h0,         32'h8000_0201, 32'h0,         32'h2,         32'h0,         32'h8000_0A00, 1, 0, 32'h8000_0A00));
    vecs.push_back(mk("trap_ov_mret", 0, 0, 3'b000, 0, 0, 1, 1, 32'h0,         32'h0,         32'h0,         32'h0,         32'h8000_1100, 32'h8000_1200, 1, 0, 32'h8000_1100));
    vecs.push_back(mk("jal_wrap",     1, 0, 3'b000, 1, 0, 0, 0, 32'hFFFF_FFF0, 32'h0,         32'h0,         32'h20,        32'h0,         32'h0,         1, 0, 32'h0000_0010));

    // reset and sequential flow
    tick(); tick();
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_valid", pc_valid, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_mis_addr", misalign_addr, 0);
    rst = 0;
    #1 chk("boot_valid", pc_valid, 0);
    tick(); chk("run_valid", pc_valid, 1); chk("seq0", pc, 32'h8000_0000);
    tick(); chk("seq1", pc, 32'h8000_0004);
    tick(); chk("seq2", pc, 32'h8000_0008);
    tick(); chk("seq3", pc, 32'h8000_000C);
    tick(); chk("seq4", pc, 32'h8000_0010);

    // stall
    if_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc, 32'h8000_0010);
      chk("stall_valid", pc_valid, 1);
    end
    if_ready = 1;
    tick(); chk("unstall_pc", pc, 32'h8000_0014);
    if_ready = 0;
    exp_pc = 32'h8000_0014;

    // redirect / branch / misalign table
    foreach (vecs[i]) begin
      apply(vecs[i]);
      #1 chk({vecs[i].name, "/redirect"}, redirect, vecs[i].exp_rd);
      tick();
      chk({vecs[i].name, "/misalign"}, misalign, vecs[i].exp_mis);
      if (vecs[i].exp_mis) chk({vecs[i].name, "/mis_addr"}, misalign_addr, vecs[i].exp_tgt);
      clear_ex();
      if (vecs[i].exp_rd) begin
        chk({vecs[i].name, "/bubble"}, pc_valid, 0);
        tick();
        exp_pc = vecs[i].exp_tgt;
      end
      chk({vecs[i].name, "/pc"}, pc, exp_pc);
      chk({vecs[i].name, "/valid"}, pc_valid, 1);
    end

    // misalign pulse with sequential flow continuing
    if_ready = 1;
    ex_valid = 1; jal = 1; ex_pc = 32'h8000_0C00; imm = 32'h1;
    #1 chk("mis_seq_redirect", redirect, 0);
    tick();
    chk("mis_seq_pulse", misalign, 1);
    chk("mis_seq_addr", misalign_addr, 32'h8000_0C01);
    chk("mis_seq_pc1", pc, exp_pc + 32'd4);
    clear_ex();
    tick();
    chk("mis_seq_drop", misalign, 0);
    chk("mis_seq_hold_addr", misalign_addr, 32'h8000_0C01);
    chk("mis_seq_pc2", pc, exp_pc + 32'd8);

    // trap beats jal, then mret during HOLD overwrites the target
    trap = 1; trap_vec = 32'h8000_1000;
    ex_valid = 1; jal = 1; ex_pc = 32'h8000_0300; imm = 32'h0;
    #1 chk("prio_redirect", redirect, 1);
    tick();
    chk("prio_hold1", pc_valid, 0);
    clear_ex();
    mret = 1; mepc = 32'h8000_0104;
    #1 chk("hold_mret_redirect", redirect, 1);
    tick();
    chk("prio_hold2", pc_valid, 0);
    clear_ex();
    tick();
    chk("prio_pc", pc, 32'h8000_0104);
    chk("prio_valid", pc_valid, 1);
    tick();
    chk("prio_seq", pc, 32'h8000_0108);

    // pc+4 wraps at the top of the address space
    trap = 1; trap_vec = 32'hFFFF_FFF8;
    tick(); clear_ex();
    tick(); chk("wrap0", pc, 32'hFFFF_FFF8);
    tick(); chk("wrap1", pc, 32'hFFFF_FFFC);
    tick(); chk("wrap2", pc, 32'h0000_0000);

    // reset during HOLD discards the latched target
    trap = 1; trap_vec = 32'h8000_3000;
    tick();
    chk("rh_hold", pc_valid, 0);
    trap_vec = 32'h8000_4000;
    rst = 1;
    #1 chk("rh_rst_masks_redirect", redirect, 0);
    tick();
    chk("rh_pc", pc, 32'h8000_0000);
    chk("rh_valid", pc_valid, 0);
    chk("rh_mis", misalign, 0);
    clear_ex();
    rst = 0; if_ready = 0;
    tick();
    chk("rh_run_valid", pc_valid, 1);
    chk("rh_run_pc", pc, 32'h8000_0000);
    tick();
    chk("rh_no_leak", pc, 32'h8000_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
